// File: rtl/avm_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM write arbiter.
package avm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Per-bit fill values driven on the shared master while no requester holds the bus
    localparam logic IDLE_ADDR_BIT = 1'b1;
    localparam logic IDLE_DATA_BIT = 1'b0;

endpackage

// File: rtl/avm_wr_arbiter_xfer_counter.sv
// Free-running completed-transfer counter; wraps silently at 2^CW.
module xfer_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/avm_wr_arbiter.sv
// Round-robin arbiter merging two Avalon-MM write requesters onto one master port.
module avm_wr_arbiter
    import avm_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          csi_clk,
    input  logic          rsi_reset,
    input  logic [AW-1:0] avs_s0_address,
    input  logic          avs_s0_write,
    input  logic [DW-1:0] avs_s0_writedata,
    output logic          avs_s0_waitrequest,
    input  logic [AW-1:0] avs_s1_address,
    input  logic          avs_s1_write,
    input  logic [DW-1:0] avs_s1_writedata,
    output logic          avs_s1_waitrequest,
    output logic [AW-1:0] avm_m0_address,
    output logic          avm_m0_write,
    output logic [DW-1:0] avm_m0_writedata,
    input  logic          avm_m0_waitrequest,
    output logic [CW-1:0] cnt_s0,
    output logic [CW-1:0] cnt_s1,
    output logic          last_grant
);

    arb_state_t state, state_nxt;
    logic       done0, done1;

    assign done0 = (state == GNT0) && avs_s0_write && !avm_m0_waitrequest;
    assign done1 = (state == GNT1) && avs_s1_write && !avm_m0_waitrequest;

    // last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (done0) begin
                last_grant <= 1'b0;
            end else if (done1) begin
                last_grant <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (avs_s0_write && avs_s1_write) begin
                    state_nxt = last_grant ? GNT0 : GNT1;
                end else if (avs_s0_write) begin
                    state_nxt = GNT0;
                end else if (avs_s1_write) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!avs_s0_write || done0) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (!avs_s1_write || done1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        avm_m0_address     = {AW{IDLE_ADDR_BIT}};
        avm_m0_write       = 1'b0;
        avm_m0_writedata   = {DW{IDLE_DATA_BIT}};
        avs_s0_waitrequest = 1'b1;
        avs_s1_waitrequest = 1'b1;
        unique case (state)
            GNT0: begin
                avm_m0_address     = avs_s0_address;
                avm_m0_write       = avs_s0_write;
                avm_m0_writedata   = avs_s0_writedata;
                avs_s0_waitrequest = avm_m0_waitrequest;
            end
            GNT1: begin
                avm_m0_address     = avs_s1_address;
                avm_m0_write       = avs_s1_write;
                avm_m0_writedata   = avs_s1_writedata;
                avs_s1_waitrequest = avm_m0_waitrequest;
            end
            default: ;
        endcase
    end

    xfer_counter #(.CW(CW)) u_cnt_s0 (
        .clk   (csi_clk),
        .rst   (rsi_reset),
        .en    (done0),
        .count (cnt_s0)
    );

    xfer_counter #(.CW(CW)) u_cnt_s1 (
        .clk   (csi_clk),
        .rst   (rsi_reset),
        .en    (done1),
        .count (cnt_s1)
    );

endmodule

// File: tb/tb_avm_wr_arbiter.sv
// Self-checking bench: directed and random traffic against a transaction-level reference model.
module tb_avm_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s0_addr = '0, s1_addr = '0, s0_data = '0, s1_data = '0;
    logic       s0_wr = 1'b0, s1_wr = 1'b0, m_wait = 1'b0;

    logic [7:0]  a_addr, a_data, b_addr, b_data;
    logic        a_wr, a_w0, a_w1, a_last, b_wr, b_w0, b_w1, b_last;
    logic [15:0] a_c0, a_c1;
    logic [3:0]  b_c0, b_c1;

    int total = 0;
    int bad   = 0;

    // Reference model: owner of the bus (-1 = nobody), last served, completed counts
    int owner, last, n0, n1;

    always #5 clk = ~clk;

    avm_wr_arbiter #(.AW(8), .DW(8), .CW(16)) dut_a (
        .csi_clk(clk), .rsi_reset(rst),
        .avs_s0_address(s0_addr), .avs_s0_write(s0_wr), .avs_s0_writedata(s0_data),
        .avs_s0_waitrequest(a_w0),
        .avs_s1_address(s1_addr), .avs_s1_write(s1_wr), .avs_s1_writedata(s1_data),
        .avs_s1_waitrequest(a_w1),
        .avm_m0_address(a_addr), .avm_m0_write(a_wr), .avm_m0_writedata(a_data),
        .avm_m0_waitrequest(m_wait),
        .cnt_s0(a_c0), .cnt_s1(a_c1), .last_grant(a_last)
    );

    avm_wr_arbiter #(.AW(8), .DW(8), .CW(4)) dut_b (
        .csi_clk(clk), .rsi_reset(rst),
        .avs_s0_address(s0_addr), .avs_s0_write(s0_wr), .avs_s0_writedata(s0_data),
        .avs_s0_waitrequest(b_w0),
        .avs_s1_address(s1_addr), .avs_s1_write(s1_wr), .avs_s1_writedata(s1_data),
        .avs_s1_waitrequest(b_w1),
        .avm_m0_address(b_addr), .avm_m0_write(b_wr), .avm_m0_writedata(b_data),
        .avm_m0_waitrequest(m_wait),
        .cnt_s0(b_c0), .cnt_s1(b_c1), .last_grant(b_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_addr, e_data;
        logic       e_wr, e_w0, e_w1;
        e_addr = 8'hFF; e_data = 8'h00; e_wr = 1'b0; e_w0 = 1'b1; e_w1 = 1'b1;
        if (owner == 0) begin
            e_addr = s0_addr; e_data = s0_data; e_wr = s0_wr; e_w0 = m_wait;
        end else if (owner == 1) begin
            e_addr = s1_addr; e_data = s1_data; e_wr = s1_wr; e_w1 = m_wait;
        end
        chk("m_write", {31'd0, a_wr}, {31'd0, e_wr});
        chk("m_addr",  {24'd0, a_addr}, {24'd0, e_addr});
        chk("m_data",  {24'd0, a_data}, {24'd0, e_data});
        chk("wait_s0", {31'd0, a_w0}, {31'd0, e_w0});
        chk("wait_s1", {31'd0, a_w1}, {31'd0, e_w1});
        chk("cnt_s0",  {16'd0, a_c0}, n0 % 65536);
        chk("cnt_s1",  {16'd0, a_c1}, n1 % 65536);
        chk("last_grant", {31'd0, a_last}, last);
        chk("cnt_s0_cw4", {28'd0, b_c0}, n0 % 16);
        chk("cnt_s1_cw4", {28'd0, b_c1}, n1 % 16);
        chk("m_write_cw4", {31'd0, b_wr}, {31'd0, e_wr});
    endtask

    // One clock: check comb outputs for the current inputs, then advance the model on the edge
    task automatic tick();
        int want0, want1;
        #1;
        check_outputs();
        @(posedge clk);
        want0 = s0_wr ? 1 : 0;
        want1 = s1_wr ? 1 : 0;
        if (!rst) begin
            if (owner < 0) begin
                if (want0 && want1) owner = 1 - last;
                else if (want0)     owner = 0;
                else if (want1)     owner = 1;
            end else if ((owner == 0 ? want0 : want1) == 0) begin
                owner = -1;
            end else if (!m_wait) begin
                if (owner == 0) n0++; else n1++;
                last  = owner;
                owner = -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        owner = -1; last = 1; n0 = 0; n1 = 0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic w0, input logic [7:0] ad0, input logic [7:0] d0,
                         input logic w1, input logic [7:0] ad1, input logic [7:0] d1,
                         input logic mw);
        s0_wr = w0; s0_addr = ad0; s0_data = d0;
        s1_wr = w1; s1_addr = ad1; s1_data = d1;
        m_wait = mw;
    endtask

    initial begin
        owner = -1; last = 1; n0 = 0; n1 = 0;
        @(negedge clk);
        do_reset();

        // Single s0 write: bus shows 05/11 for one cycle, one cycle after request
        drive(1, 8'h05, 8'h11, 0, 8'h00, 8'h00, 0);
        tick();
        chk("s0_grant_addr", {24'd0, a_addr}, 32'h05);
        chk("s0_grant_wr", {31'd0, a_wr}, 32'd1);
        tick();
        drive(0, 8'h05, 8'h11, 0, 8'h00, 8'h00, 0);
        tick();
        chk("single_cnt_s0", {16'd0, a_c0}, 32'd1);
        chk("single_last", {31'd0, a_last}, 32'd0);

        // Both requesting continuously: alternating grants starting with s0
        do_reset();
        drive(1, 8'hA0, 8'h01, 1, 8'hB0, 8'h02, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            tick();
            chk("rr_order", {31'd0, a_last}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        chk("rr_cnt_s0", {16'd0, a_c0}, 32'd4);
        chk("rr_cnt_s1", {16'd0, a_c1}, 32'd4);

        // s1 stalled by downstream for 5 cycles, s0 waiting throughout
        do_reset();
        drive(0, 8'h00, 8'h00, 1, 8'h3C, 8'h5A, 1);
        tick();
        drive(1, 8'h44, 8'h66, 1, 8'h3C, 8'h5A, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold_s1", {31'd0, a_w1}, 32'd1);
            chk("stall_s0_wait", {31'd0, a_w0}, 32'd1);
        end
        m_wait = 1'b0;
        tick();
        chk("stall_complete_cnt_s1", {16'd0, a_c1}, 32'd1);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
        tick();
        tick();

        // s0 withdraws while granted: no count, no write pulse afterwards
        drive(1, 8'h12, 8'h34, 0, 8'h00, 8'h00, 1);
        tick();
        s0_wr = 1'b0;
        tick();
        chk("withdraw_cnt_s0", {16'd0, a_c0}, 32'd0);
        tick();
        chk("withdraw_no_write", {31'd0, a_wr}, 32'd0);

        // Reset during stalled GNT0
        drive(1, 8'h77, 8'h88, 0, 8'h00, 8'h00, 1);
        tick();
        tick();
        chk("pre_reset_write", {31'd0, a_wr}, 32'd1);
        do_reset();
        chk("post_reset_cnt_s0", {16'd0, a_c0}, 32'd0);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 1), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0));
            tick();
        end

        // CW=4 wrap after 16 s0 transfers
        do_reset();
        drive(1, 8'h09, 8'h0A, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 32; i++) tick();
        chk("wrap_cw4_cnt_s0", {28'd0, b_c0}, 32'd0);
        chk("wrap_cw16_cnt_s0", {16'd0, a_c0}, 32'd16);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avm_wr_arbiter.md
AVM_WR_ARBITER -- requirements
Module: avm_wr_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, address width of all ports.
REQ-002 SHALL have parameter DW, default 8, data width of all ports.
REQ-003 SHALL have parameter CW, default 16, width of per-port completed-write counters.
REQ-004 SHALL have port csi_clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rsi_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port avs_s0_address, input, AW, requester 0 write address.
REQ-007 SHALL have port avs_s0_write, input, 1, requester 0 write request.
REQ-008 SHALL have port avs_s0_writedata, input, DW, requester 0 write data.
REQ-009 SHALL have port avs_s0_waitrequest, output, 1, stall to requester 0.
REQ-010 SHALL have ports avs_s1_address, avs_s1_write, avs_s1_writedata, avs_s1_waitrequest, identical to REQ-006 to REQ-009, for requester 1.
REQ-011 SHALL have port avm_m0_address, output, AW, shared downstream address.
REQ-012 SHALL have port avm_m0_write, output, 1, shared downstream write.
REQ-013 SHALL have port avm_m0_writedata, output, DW, shared downstream write data.
REQ-014 SHALL have port avm_m0_waitrequest, input, 1, downstream stall.
REQ-015 SHALL have ports cnt_s0 and cnt_s1, output, CW, completed writes per requester.
REQ-016 SHALL have port last_grant, output, 1, index of the most recently served requester.

Function
REQ-017 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-018 In IDLE with exactly one avs_sN_write high, SHALL move to GNTN on the next edge.
REQ-019 In IDLE with both writes high, SHALL grant the requester not equal to last_grant (round-robin).
REQ-020 In IDLE, avm_m0_write SHALL be 0, avm_m0_address all-ones, avm_m0_writedata 0, and both avs waitrequests 1.
REQ-021 In GNTN, SHALL pass avs_sN address/write/writedata combinationally to avm_m0_*.
REQ-022 In GNTN, avs_sN_waitrequest SHALL equal avm_m0_waitrequest; the other requester's waitrequest SHALL be 1.
REQ-023 In GNTN, avs_sN_write=1 and avm_m0_waitrequest=0 SHALL complete one transfer: cnt_sN increments, last_grant<=N, next state IDLE.
REQ-024 In GNTN, avm_m0_waitrequest=1 SHALL hold GNTN indefinitely; no preemption.
REQ-025 In GNTN, avs_sN_write=0 SHALL return to IDLE with no count and last_grant unchanged.
REQ-026 Arbitration latency SHALL be exactly one cycle from request in IDLE to grant; back-to-back transfers SHALL have one IDLE cycle between them.
REQ-027 cnt_sN SHALL wrap from 2^CW-1 to 0 without a flag.
REQ-028 Requests arriving during GNTx SHALL not be lost; they are held by their waitrequest=1 until granted.

Reset
REQ-029 Asserting rsi_reset SHALL immediately force state IDLE, last_grant=1 (requester 0 wins first tie), and cnt_s0=cnt_s1=0.
REQ-030 Reset mid-transfer SHALL drop avm_m0_write to 0 combinationally through the IDLE decode; the in-flight write is abandoned and not counted.
REQ-031 Release of reset SHALL take effect at the next csi_clk edge, with no spurious grant in the release cycle.

Structure
REQ-032 Package avm_arb_pkg SHALL hold the FSM enum type and the IDLE default address and data constants.
REQ-033 Completed-write counting SHALL be a sub-module xfer_counter (enable, async reset, CW-wide wrap), instantiated twice.

Verification
REQ-034 Reset, then s0 writes addr 0x05 data 0x11 with waitrequest=0: avm_m0 shows 0x05/0x11 for exactly one cycle, one cycle after the request; cnt_s0=1; last_grant=0.
REQ-035 Both requesters continuously writing with waitrequest=0: grants alternate 0,1,0,1; after 8 transfers cnt_s0=4 and cnt_s1=4.
REQ-036 s1 granted with avm_m0_waitrequest held high 5 cycles: GNT1 held 5 cycles; avs_s0_waitrequest=1 throughout; s1 completes on cycle 6.
REQ-037 s0 deasserts write while in GNT0: return to IDLE; cnt_s0 unchanged; no avm_m0_write pulse.
REQ-038 rsi_reset asserted during a stalled GNT0: avm_m0_write falls immediately; counters are 0 and state is IDLE after release.
REQ-039 With CW=4, 16 s0 transfers: cnt_s0 wraps to 0.
